data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 2, number of extra cycles between request accept and response (0..15).
REQ-003 SHALL have one clock and a synchronous active-low reset; `clk` and `reset` are ports 1 and 2.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous reset, active-low (reset==0 resets on next clk edge).
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data; byte/half taken from LSBs.
REQ-011 req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-012 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  initiator consumes the response.
REQ-015 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  request was misaligned, out of range or illegal size.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-018 Handshake: request accepted on a clk edge with req_valid & req_ready; all req_* fields latched at accept.
REQ-019 After accept, FSM enters WAIT with a down-counter loaded with WAIT_STATES; it leaves WAIT for RESP when the counter is 0, so rsp_valid first asserts exactly WAIT_STATES+1 cycles after accept.
REQ-020 WAIT_STATES=0: FSM goes IDLE -> RESP directly; rsp_valid asserts in the cycle after accept.
REQ-021 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1; on that edge FSM returns to IDLE; a new request is accepted no earlier than the following cycle.
REQ-022 Error if size=11, half at an odd address, word at an address with addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS; errored stores SHALL NOT modify storage.
REQ-023 Store writes only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and addr[1]*2+1); the write occurs once, on the edge entering RESP.
REQ-024 Load reads the word at addr[31:2], selects the lane(s) by addr[1:0], and sign- or zero-extends to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-025 req_valid while not in IDLE SHALL be ignored (no accept, no storage effect).
REQ-026 Storage contents are undefined after power-up and are not cleared by reset.

Reset
REQ-027 reset==0 at a clk edge SHALL force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0, from any state.
REQ-028 Reset during WAIT or RESP aborts the transaction; a pending store not yet committed SHALL NOT be written.
REQ-029 While reset==0, req_ready SHALL be 0 and no request is accepted.

Structure
REQ-030 Shared package klp32_pkg SHALL hold the mem_size_t enum (BYTE, HALF, WORD) and the responder state enum.
REQ-031 Storage SHALL be a sub-module mem_array_be (one write port with 4-bit byte enable, one asynchronous read port); FSM, alignment check and extension live in data_mem_responder.

Verification
REQ-032 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata 0xDEADBEEF, err 0; rsp_valid exactly 3 cycles after each accept (WAIT_STATES=2).
REQ-033 After REQ-032, store byte 0x80 @0x11, then load byte signed @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0xDEAD80EF.
REQ-034 Load half @0x13 -> err 1, rdata 0; store word @0x12 with data 0x0 -> err 1, word @0x10 unchanged.
REQ-035 Load word @(DEPTH_WORDS*4) -> err 1; size=11 -> err 1.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; req_valid pulses ignored.
REQ-037 Assert reset==0 during WAIT of a store 0x12345678 @0x20 -> IDLE next cycle, rsp_valid 0, later load @0x20 does not return 0x12345678 (pre-seeded 0x0).

Source files
------------

// File: rtl/klp32_pkg.sv
// Shared types and helpers for the klp32 data-memory responder.
// Holds the access-size and responder-state enums, plus the byte-lane
// helpers used by both the store path and the load-extension path.
package klp32_pkg;

  // Access size carried on req_size; 2'b11 is not a legal size.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Responder FSM state, also exported for debug observation.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } rsp_state_t;

  // Byte lanes touched by an access of the given size at byte offset lo.
  function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      MEM_BYTE: mask = 4'b0001 << lo;
      MEM_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replicate the store LSBs across all lanes; the lane mask picks the live ones.
  function automatic logic [31:0] store_lanes(logic [1:0] size, logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = wdata;
    case (size)
      MEM_BYTE: lanes = {4{wdata[7:0]}};
      MEM_HALF: lanes = {2{wdata[15:0]}};
      default:  lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Pick the addressed lane(s) out of a stored word and extend to 32 bits.
  function automatic logic [31:0] extend_load(logic [31:0] word, logic [1:0] size,
                                              logic [1:0] lo, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: res = {{24{b[7] & ~uns}}, b};
      MEM_HALF: res = {{16{h[15] & ~uns}}, h};
      MEM_WORD: res = word;
      default:  res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (master) and the data-memory
// responder (slave).
//
// Handshake rules: a request transfers on a rising clk edge where
// req_valid & req_ready are both 1; a response transfers on a rising edge
// where rsp_valid & rsp_ready are both 1. A side asserting valid keeps its
// payload stable until the transfer edge. The responder handles exactly one
// transaction at a time, so req_ready is low from accept until the
// response has been consumed.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_array_be.sv
// Word-organised storage with one byte-enabled write port and one
// asynchronous read port. Contents are never reset.
module mem_array_be #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) begin
          mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store,
// waits WAIT_STATES extra cycles, then presents the response until the
// initiator consumes it. Alignment/range checking and load extension
// live here; storage is the mem_array_be sub-module.
module data_mem_responder
  import klp32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus_if,
  output rsp_state_t           state_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  rsp_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request fields captured at accept.
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  // Registered response payload.
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        latch_en;
  logic        commit;

  // The transaction being worked on: live bus fields while idle (needed for
  // the zero-wait path that commits on the accept edge), latched otherwise.
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic        sel_err;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rword;
  logic [31:0] load_data;

  assign bus_if.req_ready = reset && (state_q == ST_IDLE);
  assign bus_if.rsp_valid = (state_q == ST_RESP);
  assign bus_if.rsp_rdata = rdata_q;
  assign bus_if.rsp_err   = err_q;
  assign state_o          = state_q;

  assign accept = bus_if.req_valid && bus_if.req_ready;

  // Choose between the live request and the latched one.
  always_comb begin
    sel_we    = we_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_size  = size_q;
    sel_uns   = uns_q;
    if (state_q == ST_IDLE) begin
      sel_we    = bus_if.req_we;
      sel_addr  = bus_if.req_addr;
      sel_wdata = bus_if.req_wdata;
      sel_size  = bus_if.req_size;
      sel_uns   = bus_if.req_unsigned;
    end
  end

  // Illegal size, misalignment or word index beyond the array.
  assign sel_err = (sel_size == SIZE_ILLEGAL)
                 | ((sel_size == MEM_HALF) & sel_addr[0])
                 | ((sel_size == MEM_WORD) & (sel_addr[1:0] != 2'b00))
                 | ({2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS));

  // FSM next state; commit marks the edge that enters RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = reset;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus_if.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response payload: computed on the commit edge, cleared once consumed.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = sel_err;
      rdata_d = (sel_err || sel_we) ? 32'h0 : load_data;
    end else if ((state_q == ST_RESP) && bus_if.rsp_ready) begin
      rdata_d = 32'h0;
      err_d   = 1'b0;
    end
  end

  // State, counter, latched request and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch_en) begin
        we_q    <= bus_if.req_we;
        addr_q  <= bus_if.req_addr;
        wdata_q <= bus_if.req_wdata;
        size_q  <= bus_if.req_size;
        uns_q   <= bus_if.req_unsigned;
      end
    end
  end

  // Storage write happens once, on the commit edge, and never for errors.
  assign mem_we    = commit & sel_we & ~sel_err;
  assign mem_be    = lane_mask(sel_size, sel_addr[1:0]);
  assign mem_wdata = store_lanes(sel_size, sel_wdata);
  assign load_data = extend_load(mem_rword, sel_size, sel_addr[1:0], sel_uns);

  mem_array_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .waddr_i (sel_addr[AW+1:2]),
    .wdata_i (mem_wdata),
    .raddr_i (sel_addr[AW+1:2]),
    .rdata_o (mem_rword)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized
// loads/stores checked against a byte-addressed reference memory.
module tb_data_mem_responder;
  import klp32_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();
  rsp_state_t state;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus_if  (bus),
    .state_o (state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory, one entry per byte, little-endian.
  logic [7:0] ref_mem [DEPTH*4];

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: error rules, byte-lane update, load extension.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              output logic [31:0] rd, output logic err);
    int nbytes;
    logic [31:0] val;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr % nbytes) != 0) || ((addr >> 2) >= 32'(DEPTH));
    rd  = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[int'(addr) + i]) << (8*i));
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8*nbytes));
      rd = val;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, output bit ok);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("req_ready before accept", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
  endtask

  // Full transaction: accept, latency, payload, optional hold with junk
  // req_valid pulses, then consumption.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold,
                        input string tag, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          ok;
    int          lat;
    model_access(we, addr, wdata, size, uns, exp_rd, exp_err);
    start_req(we, addr, wdata, size, uns, ok);
    rd = 32'h0;
    if (!ok) return;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    check_eq({tag, " latency"}, 32'(lat), 32'(WS + 1));
    check_eq({tag, " rdata"}, bus.rsp_rdata, exp_rd);
    check_eq({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
    check_eq({tag, " req_ready in resp"}, 32'(bus.req_ready), 32'd0);
    rd = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'($urandom_range(0, DEPTH - 1) * 4);
      bus.req_size  = 2'(MEM_WORD);
      bus.req_wdata = $urandom;
      @(posedge clk); #1;
      check_eq({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
      check_eq({tag, " hold rdata"}, bus.rsp_rdata, exp_rd);
      check_eq({tag, " hold err"}, 32'(bus.rsp_err), 32'(exp_err));
      check_eq({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_eq({tag, " valid after consume"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, " ready after consume"}, 32'(bus.req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [1:0]  sz;
    logic [31:0] a;
    bit          ok;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;

    // Reset state, with a request offered during reset that must be ignored.
    reset = 1'b0;
    bus.req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("reset state", 32'(state), 32'(ST_IDLE));
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("post-reset req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Seed every word so the reference memory is fully defined.
    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b1, 32'(w * 4), $urandom, 2'(MEM_WORD), 1'b0, 0, "seed", rd);
    end

    // Word store/load round trip.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 2'(MEM_WORD), 1'b0, 0, "st w 0x10", rd);
    do_req(1'b0, 32'h10, 32'h0, 2'(MEM_WORD), 1'b0, 0, "ld w 0x10", rd);
    check_eq("ld w 0x10 const", rd, 32'hDEAD_BEEF);

    // Byte store and signed/unsigned byte loads.
    do_req(1'b1, 32'h11, 32'h0000_0080, 2'(MEM_BYTE), 1'b0, 0, "st b 0x11", rd);
    do_req(1'b0, 32'h11, 32'h0, 2'(MEM_BYTE), 1'b0, 0, "ld bs 0x11", rd);
    check_eq("ld bs 0x11 const", rd, 32'hFFFF_FF80);
    do_req(1'b0, 32'h11, 32'h0, 2'(MEM_BYTE), 1'b1, 0, "ld bu 0x11", rd);
    check_eq("ld bu 0x11 const", rd, 32'h0000_0080);
    do_req(1'b0, 32'h10, 32'h0, 2'(MEM_WORD), 1'b0, 0, "ld w 0x10 b", rd);
    check_eq("ld w 0x10 after byte const", rd, 32'hDEAD_80EF);

    // Error cases: misaligned half, misaligned word store, range, size 11.
    do_req(1'b0, 32'h13, 32'h0, 2'(MEM_HALF), 1'b0, 0, "ld h 0x13", rd);
    do_req(1'b1, 32'h12, 32'h0, 2'(MEM_WORD), 1'b0, 0, "st w 0x12", rd);
    do_req(1'b0, 32'h10, 32'h0, 2'(MEM_WORD), 1'b0, 0, "ld w 0x10 c", rd);
    check_eq("word 0x10 unchanged const", rd, 32'hDEAD_80EF);
    do_req(1'b0, 32'(DEPTH * 4), 32'h0, 2'(MEM_WORD), 1'b0, 0, "ld oor", rd);
    do_req(1'b0, 32'h14, 32'h0, SIZE_ILLEGAL, 1'b0, 0, "size 11", rd);
    do_req(1'b1, 32'h14, 32'hFFFF_FFFF, SIZE_ILLEGAL, 1'b0, 0, "st size 11", rd);
    do_req(1'b0, 32'h12, 32'h0, 2'(MEM_HALF), 1'b0, 0, "ld hs 0x12", rd);
    check_eq("ld hs 0x12 const", rd, 32'hFFFF_DEAD);

    // Long backpressure in RESP.
    do_req(1'b0, 32'h10, 32'h0, 2'(MEM_WORD), 1'b0, 5, "hold5", rd);

    // Reset during WAIT of a store: the store must not land.
    do_req(1'b1, 32'h20, 32'h0, 2'(MEM_WORD), 1'b0, 0, "preseed 0x20", rd);
    start_req(1'b1, 32'h20, 32'h1234_5678, 2'(MEM_WORD), 1'b0, ok);
    check_eq("rst wait: in WAIT", 32'(state), 32'(ST_WAIT));
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst wait: state", 32'(state), 32'(ST_IDLE));
    check_eq("rst wait: rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst wait: req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst wait: rdata", bus.rsp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst wait: no late resp", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rst wait: ready on release", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 2'(MEM_WORD), 1'b0, 0, "ld 0x20 after rst", rd);
    check_eq("aborted store not written", rd, 32'h0);

    // Reset while a response is being held.
    start_req(1'b0, 32'h10, 32'h0, 2'(MEM_WORD), 1'b0, ok);
    repeat (WS + 1) @(posedge clk);
    #1;
    check_eq("rst resp: valid before", 32'(bus.rsp_valid), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst resp: valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst resp: rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst resp: err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst resp: state", 32'(state), 32'(ST_IDLE));
    reset = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
      do_req(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), "rand", rd);
    end

    // Read back a spread of words to catch stray writes.
    for (int w = 0; w < DEPTH; w += 7) begin
      do_req(1'b0, 32'(w * 4), 32'h0, 2'(MEM_WORD), 1'b0, 0, "sweep", rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
